// File: rtl/image_shear_stream.sv
// Streaming frame shear engine: buffers one ROWS x COLS frame, then emits the sheared raster by inverse mapping.
// Optional macro SHEAR_NEG_EN makes the shear factor two's complement and anchors negative shears inside the output.
module image_shear_stream #(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int DATA_W  = 8,
  parameter int SH_FRAC = 8,
  parameter int SH_W    = 10,
  parameter int MAX_EXT = 32,
  parameter int FILL    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [SH_W-1:0]   shear,
  output logic              busy,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              out_eof,
  output logic [15:0]       out_rows,
  output logic [15:0]       out_cols
);

  localparam int NPIX  = ROWS * COLS;
  localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int ACC_W = SH_W + 16;
  localparam int CW    = ACC_W + 2;
  localparam logic signed [CW-1:0] ROWS_S = CW'(ROWS);
  localparam logic signed [CW-1:0] COLS_S = CW'(COLS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;
  typedef enum logic [1:0] {M_BYP = 2'd0, M_HOR = 2'd1, M_VER = 2'd2} mode_t;

  state_t             r_state, w_state_nx;
  mode_t              r_mode;
  logic [SH_W-1:0]    r_mag;
  logic               r_neg;
  logic [AW-1:0]      r_in_cnt;
  logic [15:0]        r_ext, r_rows, r_cols, r_oi, r_oj;
  logic [ACC_W-1:0]   r_acc;
  logic               r_gen_done, r_cfg_err;
  logic               r_out_valid, r_out_eol, r_out_eof;
  logic [DATA_W-1:0]  r_out_data;
  logic [DATA_W-1:0]  r_mem [NPIX];

  logic [SH_W-1:0]    w_mag_in;
  logic               w_neg_in;

`ifdef SHEAR_NEG_EN
  assign w_neg_in = shear[SH_W-1];
  assign w_mag_in = w_neg_in ? (~shear + SH_W'(1)) : shear;
`else
  assign w_neg_in = 1'b0;
  assign w_mag_in = shear;
`endif

  // Extent from the latched magnitude; the product is floored by dropping the fraction bits.
  logic [ACC_W-1:0] w_prod, w_ext;
  logic             w_over;
  logic [15:0]      w_rows, w_cols;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_prod = '0;
    case (r_mode)
      M_HOR:   w_prod = ACC_W'(ROWS - 1) * ACC_W'(r_mag);
      M_VER:   w_prod = ACC_W'(COLS - 1) * ACC_W'(r_mag);
      default: w_prod = '0;
    endcase
  end

  assign w_ext  = w_prod >> SH_FRAC;
  assign w_over = (w_ext > ACC_W'(MAX_EXT));

  always_comb begin
    w_rows = 16'(ROWS);
    w_cols = 16'(COLS);
    if (r_mode == M_HOR) w_cols = 16'(COLS) + 16'(w_ext);
    if (r_mode == M_VER) w_rows = 16'(ROWS) + 16'(w_ext);
  end

  logic w_in_hs, w_last_in, w_out_hs, w_load, w_eol, w_eof;
  assign w_in_hs   = in_valid && (r_state == S_LOAD);
  assign w_last_in = w_in_hs && (r_in_cnt == AW'(NPIX - 1));
  assign w_out_hs  = r_out_valid && out_ready;
  assign w_load    = (r_state == S_EMIT) && !r_gen_done && (!r_out_valid || out_ready);
  assign w_eol     = (r_oj == r_cols - 16'd1);
  assign w_eof     = w_eol && (r_oi == r_rows - 16'd1);

  // Inverse mapping of the current output coordinate to a signed source coordinate.
  logic [ACC_W-1:0]      w_off_u;
  logic signed [CW-1:0]  w_off, w_oi_s, w_oj_s, w_ext_s, w_si, w_sj;
  logic                  w_in_range;
  logic [AW-1:0]         w_addr;
  logic [DATA_W-1:0]     w_pix;

  assign w_off_u = r_acc >> SH_FRAC;
  assign w_off   = signed'(CW'(w_off_u));
  assign w_oi_s  = signed'(CW'(r_oi));
  assign w_oj_s  = signed'(CW'(r_oj));
  assign w_ext_s = signed'(CW'(r_ext));

  always_comb begin
    w_si = w_oi_s;
    w_sj = w_oj_s;
    case (r_mode)
      M_HOR:   w_sj = r_neg ? (w_oj_s - w_ext_s + w_off) : (w_oj_s - w_off);
      M_VER:   w_si = r_neg ? (w_oi_s - w_ext_s + w_off) : (w_oi_s - w_off);
      default: ;
    endcase
  end

  assign w_in_range = (w_si >= 0) && (w_si < ROWS_S) && (w_sj >= 0) && (w_sj < COLS_S);
  assign w_addr     = AW'(w_si * COLS_S + w_sj);
  assign w_pix      = w_in_range ? r_mem[w_addr] : DATA_W'(FILL);

  // NOTE: the frame buffer is not reset; every location is written in LOAD before EMIT reads it.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_mem[r_in_cnt] <= in_data;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_LOAD;
      S_LOAD:  if (w_last_in) w_state_nx = w_over ? S_IDLE : S_EMIT;
      S_EMIT:  if (w_out_hs && r_out_eof) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= M_BYP;
      r_mag       <= '0;
      r_neg       <= 1'b0;
      r_in_cnt    <= '0;
      r_ext       <= '0;
      r_rows      <= '0;
      r_cols      <= '0;
      r_oi        <= '0;
      r_oj        <= '0;
      r_acc       <= '0;
      r_gen_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        case (mode)
          2'd1:    r_mode <= M_HOR;
          2'd2:    r_mode <= M_VER;
          default: r_mode <= M_BYP;
        endcase
        r_mag     <= w_mag_in;
        r_neg     <= w_neg_in;
        r_cfg_err <= 1'b0;
        r_in_cnt  <= '0;
      end

      if (r_state == S_LOAD) begin
        r_ext      <= 16'(w_ext);
        r_rows     <= w_rows;
        r_cols     <= w_cols;
        r_oi       <= '0;
        r_oj       <= '0;
        r_acc      <= '0;
        r_gen_done <= 1'b0;
      end
      if (w_in_hs)               r_in_cnt  <= r_in_cnt + AW'(1);
      if (w_last_in && w_over)   r_cfg_err <= 1'b1;

      // Output register: refill when empty or when the held pixel is taken.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pix;
        r_out_eol   <= w_eol;
        r_out_eof   <= w_eof;
        if (w_eof) r_gen_done <= 1'b1;
        if (w_eol) begin
          r_oj <= '0;
          r_oi <= r_oi + 16'd1;
          if (r_mode == M_HOR) r_acc <= r_acc + ACC_W'(r_mag);
          if (r_mode == M_VER) r_acc <= '0;
        end else begin
          r_oj <= r_oj + 16'd1;
          if (r_mode == M_VER) r_acc <= r_acc + ACC_W'(r_mag);
        end
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_LOAD);
  assign cfg_err   = r_cfg_err;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_eol   = r_out_eol;
  assign out_eof   = r_out_eof;
  assign out_rows  = r_rows;
  assign out_cols  = r_cols;

endmodule

// File: tb/tb_image_shear_stream.sv
// Directed, table-driven bench for image_shear_stream on a 4x4 frame with MAX_EXT = 8.
module tb_image_shear_stream;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int SW   = 10;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic          busy, cfg_err, out_eol, out_eof;
  logic [1:0]    mode;
  logic [SW-1:0] shear;
  logic [DW-1:0] in_data, out_data;
  logic [15:0]   out_rows, out_cols;

  always #5 clk = ~clk;

  image_shear_stream #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .SH_FRAC(8), .SH_W(SW), .MAX_EXT(8), .FILL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .shear(shear),
    .busy(busy), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eol(out_eol), .out_eof(out_eof), .out_rows(out_rows), .out_cols(out_cols)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [SW-1:0] shear;
    bit            rnd;
    bit            err;
    int            rows;
    int            cols;
    int            base;
  } vec_t;

  vec_t vecs[8];

  // Expected output pixels, concatenated per geometry (offsets in vec_t.base).
  int exp_all [132] = '{
    // bypass 4x4
    1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16,
    // mode 1, s = 0.5 -> 4x5
    1, 2, 3, 4, 0,   5, 6, 7, 8, 0,   0, 9, 10, 11, 12,   0, 13, 14, 15, 16,
    // mode 2, s = 0.5 -> 5x4
    1, 2, 0, 0,   5, 6, 3, 4,   9, 10, 7, 8,   13, 14, 11, 12,   0, 0, 15, 16,
    // mode 2, s = 1.0 -> 7x4
    1, 0, 0, 0,   5, 2, 0, 0,   9, 6, 3, 0,   13, 10, 7, 4,
    0, 14, 11, 8,   0, 0, 15, 12,   0, 0, 0, 16,
    // mode 1, s = 2.75 -> 4x12 (ext exactly MAX_EXT)
    1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 9, 10, 11, 12, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 13, 14, 15, 16
  };

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctrl"}, {26'd0, busy, cfg_err, in_ready, out_valid, out_eol, out_eof}, 32'd0);
    check({tag, "_data"}, {24'd0, out_data}, 32'd0);
    check({tag, "_geom"}, {out_rows, out_cols}, 32'd0);
  endtask

  // Runs one frame from the table; abort_at >= 0 stops after that many output handshakes.
  task automatic run_vec(input int v, input int abort_at);
    vec_t t;
    int   n, k, cyc, first, last, lim, bad;
    logic hs, stalled, h_eol, h_eof;
    logic [DW-1:0] h_data;
    t = vecs[v];
    n = t.rows * t.cols;

    // in_valid while IDLE must be ignored.
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    mode = t.mode; shear = t.shear; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = 2'd2; shear = '1;
    check($sformatf("v%0d_load_ctrl", v), {29'd0, busy, cfg_err, in_ready}, 32'b101);

    k = 0; cyc = 0;
    while (k < ROWS * COLS && cyc < 400) begin
      in_valid = t.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? 8'(k + 1) : 8'hEE;
      start    = (k == 5);
      hs       = in_valid && in_ready;
      @(posedge clk);
      if (hs) k++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    check($sformatf("v%0d_inputs_taken", v), k, ROWS * COLS);

    if (t.err) begin
      check($sformatf("v%0d_err_state", v), {30'd0, cfg_err, busy}, 32'b10);
      bad = 0;
      out_ready = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (out_valid) bad++;
      end
      check($sformatf("v%0d_no_output", v), bad, 0);
      return;
    end

    check($sformatf("v%0d_geom", v), {out_rows, out_cols}, {16'(t.rows), 16'(t.cols)});

    k = 0; cyc = 0; first = -1; last = -1; stalled = 1'b0;
    h_eol = 1'b0; h_eof = 1'b0; h_data = '0;
    lim = (abort_at >= 0) ? abort_at : n;
    while (k < lim && cyc < 600) begin
      out_ready = t.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled)
        check($sformatf("v%0d_stall_hold", v), {21'd0, out_valid, out_eol, out_eof, out_data},
              {21'd0, 1'b1, h_eol, h_eof, h_data});
      stalled = 1'b0;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (out_ready) begin
          check($sformatf("v%0d_pix%0d", v, k), {24'd0, out_data}, 32'(exp_all[t.base + k]));
          check($sformatf("v%0d_flags%0d", v, k), {30'd0, out_eol, out_eof},
                {30'd0, (k % t.cols) == t.cols - 1, k == n - 1});
          last = cyc;
          k++;
        end else begin
          stalled = 1'b1; h_eol = out_eol; h_eof = out_eof; h_data = out_data;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d_out_count", v), k, lim);
    out_ready = 1'b1;
    if (abort_at >= 0) return;
    if (!t.rnd) begin
      check($sformatf("v%0d_first_latency", v), first, 1);
      check($sformatf("v%0d_full_rate", v), last, n);
    end
    check($sformatf("v%0d_idle_after", v), {30'd0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mode: 2'd0, shear: 10'h000, rnd: 1'b0, err: 1'b0, rows: 4, cols: 4,  base: 0};
    vecs[1] = '{mode: 2'd1, shear: 10'h080, rnd: 1'b0, err: 1'b0, rows: 4, cols: 5,  base: 16};
    vecs[2] = '{mode: 2'd2, shear: 10'h080, rnd: 1'b0, err: 1'b0, rows: 5, cols: 4,  base: 36};
    vecs[3] = '{mode: 2'd1, shear: 10'h080, rnd: 1'b1, err: 1'b0, rows: 4, cols: 5,  base: 16};
    vecs[4] = '{mode: 2'd3, shear: 10'h155, rnd: 1'b1, err: 1'b0, rows: 4, cols: 4,  base: 0};
    vecs[5] = '{mode: 2'd1, shear: 10'h300, rnd: 1'b0, err: 1'b1, rows: 4, cols: 13, base: 0};
    vecs[6] = '{mode: 2'd2, shear: 10'h100, rnd: 1'b0, err: 1'b0, rows: 7, cols: 4,  base: 56};
    vecs[7] = '{mode: 2'd1, shear: 10'h2C0, rnd: 1'b0, err: 1'b0, rows: 4, cols: 12, base: 84};

    rst_n = 1'b0; start = 1'b0; mode = 2'd0; shear = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) run_vec(v, -1);

    // Reset in the middle of EMIT, then the same frame again from a fresh start.
    run_vec(1, 6);
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
